day7_piso_serializer: RTL and testbench
=======================================

Name: day7_piso_serializer

Overview:
Parallel-in, serial-out shift register. It is the transmit-side counterpart of the day 6 serial-in shift register: it accepts a WIDTH-bit word over a valid/ready handshake and drives it out one bit per clock on x_o. x_valid_o qualifies each bit, so a downstream serial-in register can capture the frame directly. Back-to-back words stream with no idle gap.

Parameters:
WIDTH, 4, data word width in bits; must be >= 2.
MSB_FIRST, 1, 1 = data_i[WIDTH-1] is sent first; 0 = data_i[0] is sent first.

Ports:
clk  input  1  clock, rising-edge active
reset  input  1  asynchronous reset, active-high
data_i  input  WIDTH  parallel word to serialize
valid_i  input  1  data_i is valid
ready_o  output  1  block can accept a word this cycle
x_o  output  1  serial data out
x_valid_o  output  1  x_o carries a frame bit this cycle
done_o  output  1  one-cycle pulse marking the cycle in which the final bit of a frame is on x_o

Behaviour:
- One clock domain (clk). reset is asynchronous and active-high: on assertion, all state clears immediately, without waiting for a clock edge.
- Reset values: x_o=0, x_valid_o=0, done_o=0, ready_o=1, FSM=IDLE, bit counter=0, shift register=0.
- FSM states (PARITY exists only with the optional feature):
  - IDLE -> SHIFT on accept.
  - SHIFT -> SHIFT while bits remain.
  - After the last data bit: SHIFT -> SHIFT on a new accept, or -> IDLE with no accept.
- Accept condition: valid_i && ready_o at a rising clk edge.
- ready_o is combinational from state only (never from valid_i). It is 1 in IDLE and 1 in SHIFT during the final bit cycle; 0 otherwise.
- On accept:
  - data_i is loaded into the shift register.
  - The first bit appears on x_o, with x_valid_o=1, in the cycle immediately after the accepting edge (latency 1).
  - The counter is set to 0.
- In SHIFT, each rising edge advances one bit and increments the counter. Bit order follows MSB_FIRST.
- Each frame occupies exactly WIDTH consecutive cycles with x_valid_o=1.
- done_o is registered and is 1 exactly in the cycle carrying the final bit.
- Back-to-back: if an accept occurs during the final bit cycle, the next frame's first bit follows with no gap. x_valid_o stays 1 throughout; done_o pulses once per frame.
- No accept at the final edge: next cycle x_valid_o=0, x_o=0, state IDLE.
- Changes on data_i or valid_i while ready_o=0 are ignored; the frame in flight is unaffected.
- Counter width is $clog2(WIDTH+1). It wraps to 0 on each new frame and never exceeds WIDTH-1.
- Reset asserted mid-frame: the frame is aborted and discarded, outputs return to reset values, and no done_o pulse is produced. After reset release the block is in IDLE with ready_o=1.

Optional Feature:
Macro: PISO_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one even-parity bit (XOR of the loaded word) is sent in state PARITY, with x_valid_o=1. Frames are WIDTH+1 cycles long.
  - done_o and ready_o=1 move to the parity cycle; they are not asserted in the last data cycle.
  - Parity is computed at load time and stored in a flop.
  - Back-to-back acceptance occurs during the parity cycle.
- Not defined: no PARITY state, no parity flop. Frames are WIDTH cycles, as described above.

Test Plan:
1. Reset: hold reset=1 for 2 cycles with valid_i=1 -> x_o=0, x_valid_o=0, done_o=0, ready_o=1, no accept occurs.
2. Single frame, WIDTH=4, MSB_FIRST=1, data_i=4'b1011 pulsed for one cycle -> x_o = 1,0,1,1 on the 4 cycles after accept; x_valid_o=1 for exactly 4 cycles; done_o=1 only in the 4th; ready_o=0 in cycles 1-3. Repeat with MSB_FIRST=0 -> x_o = 1,1,0,1.
3. Back-to-back: valid_i held high, 4'b1010 then 4'b0110 -> 8 contiguous bits 1,0,1,0,0,1,1,0; x_valid_o never drops; done_o pulses in cycles 4 and 8.
4. Busy-time input: after accepting 4'b1100, drive data_i=4'b0011 with valid_i=1 during cycles 1-2 -> x_o still 1,1,0,0; 4'b0011 is accepted at the final-bit edge and follows with no gap.
5. Mid-frame reset: accept 4'b1111, assert reset asynchronously between edges after 2 bits -> x_o and x_valid_o go to 0 before the next edge; no done_o; after release, a frame of 4'b0101 serializes as 0,1,0,1.
6. PISO_PARITY_EN defined: 4'b1011 -> x_o = 1,0,1,1,1 (parity=1); 4'b1001 -> 1,0,0,1,0; done_o and ready_o=1 only in the 5th cycle.

Source files
------------

// File: rtl/day7_piso_serializer.sv
// day7_piso_serializer: parallel-in, serial-out shift register.
// Accepts a WIDTH-bit word over valid/ready and drives it out one bit per
// clock on x_o, qualified by x_valid_o. done_o marks the final bit of a frame.
// A word offered during the final bit cycle streams out with no idle gap.
// Optional feature macro: PISO_PARITY_EN appends one even-parity bit per frame.
module day7_piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             x_o,
    output logic             x_valid_o,
    output logic             done_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_M1  = CNT_W'(WIDTH - 2);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1
`ifdef PISO_PARITY_EN
        , ST_PARITY = 2'd2
`endif
    } state_t;

    // Bit that leaves the word first, honouring the configured bit order.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its first-out bit removed, remaining bits moved into place.
    function automatic logic [WIDTH-1:0] drop_first(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

`ifdef PISO_PARITY_EN
    // Even parity: the appended bit makes the total count of ones even.
    function automatic logic even_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             done_q, done_d;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif
    logic             ready_s;
    logic             accept_s;
    logic             load_s;
    logic             idle_s;

    // Ready depends on state only: idle, or the last cycle of the current frame.
    always_comb begin
        ready_s = 1'b0;
        case (state_q)
            ST_IDLE:   ready_s = 1'b1;
`ifdef PISO_PARITY_EN
            ST_SHIFT:  ready_s = 1'b0;
            ST_PARITY: ready_s = 1'b1;
`else
            ST_SHIFT:  ready_s = (cnt_q == LAST_IDX);
`endif
            default:   ready_s = 1'b0;
        endcase
    end

    assign accept_s = valid_i && ready_s;

    // Next-state and next-output logic; loading a word and going idle are shared paths.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sreg_d    = sreg_q;
        x_d       = 1'b0;
        x_valid_d = 1'b0;
        done_d    = 1'b0;
`ifdef PISO_PARITY_EN
        par_d     = par_q;
`endif
        load_s    = 1'b0;
        idle_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                load_s = accept_s;
                idle_s = !accept_s;
            end
            ST_SHIFT: begin
                if (cnt_q != LAST_IDX) begin
                    x_d       = first_bit(sreg_q);
                    sreg_d    = drop_first(sreg_q);
                    cnt_d     = cnt_q + CNT_W'(1);
                    x_valid_d = 1'b1;
`ifdef PISO_PARITY_EN
                    done_d    = 1'b0;
`else
                    done_d    = (cnt_q == LAST_M1);
`endif
                end else begin
`ifdef PISO_PARITY_EN
                    state_d   = ST_PARITY;
                    x_d       = par_q;
                    x_valid_d = 1'b1;
                    done_d    = 1'b1;
                    sreg_d    = {WIDTH{1'b0}};
`else
                    load_s    = accept_s;
                    idle_s    = !accept_s;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                load_s = accept_s;
                idle_s = !accept_s;
            end
`endif
            default: begin
                idle_s = 1'b1;
            end
        endcase

        if (load_s) begin
            state_d   = ST_SHIFT;
            sreg_d    = drop_first(data_i);
            x_d       = first_bit(data_i);
            x_valid_d = 1'b1;
            done_d    = 1'b0;
            cnt_d     = {CNT_W{1'b0}};
`ifdef PISO_PARITY_EN
            par_d     = even_parity(data_i);
`endif
        end else if (idle_s) begin
            state_d   = ST_IDLE;
            cnt_d     = {CNT_W{1'b0}};
            sreg_d    = {WIDTH{1'b0}};
`ifdef PISO_PARITY_EN
            par_d     = 1'b0;
`endif
        end else begin
            // Mid-frame: values chosen in the case statement stand.
            load_s    = 1'b0;
        end
    end

    // State, counter, shift register and registered outputs; reset aborts any frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            sreg_q    <= {WIDTH{1'b0}};
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sreg_q    <= sreg_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            done_q    <= done_d;
`ifdef PISO_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign ready_o   = ready_s;
    assign x_o       = x_q;
    assign x_valid_o = x_valid_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_day7_piso_serializer.sv
// Bench for day7_piso_serializer: two instances (MSB-first and LSB-first)
// share one stimulus stream. A queue model of the bits due on the line is
// compared every cycle; literal stream expectations pin the model.
// Honours PISO_PARITY_EN when defined for the build.
module tb_day7_piso_serializer;

    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = W + PAR;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] data_i;
    logic         valid_i;
    logic         rdy_m, x_m, xv_m, dn_m;
    logic         rdy_l, x_l, xv_l, dn_l;

    int errors = 0;
    int checks = 0;

    day7_piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i),
        .ready_o(rdy_m), .x_o(x_m), .x_valid_o(xv_m), .done_o(dn_m)
    );

    day7_piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i),
        .ready_o(rdy_l), .x_o(x_l), .x_valid_o(xv_l), .done_o(dn_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of the bits still to appear on the line, front = bit on the line now.
    typedef struct {
        bit bm;
        bit bl;
        bit last;
    } ent_t;
    ent_t mq[$];
    bit   m_rdy;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
        end else begin
            m_rdy = (mq.size() <= 1);
            if (mq.size() > 0) void'(mq.pop_front());
            if (valid_i && m_rdy) begin
                for (int i = 0; i < W; i++) begin
                    ent_t e;
                    e.bm   = data_i[W-1-i];
                    e.bl   = data_i[i];
                    e.last = (PAR == 0) && (i == W - 1);
                    mq.push_back(e);
                end
                if (PAR != 0) begin
                    ent_t p;
                    p.bm   = ^data_i;
                    p.bl   = ^data_i;
                    p.last = 1'b1;
                    mq.push_back(p);
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic ev, em, el, ed, er;
        ev = (mq.size() > 0);
        em = ev ? mq[0].bm : 1'b0;
        el = ev ? mq[0].bl : 1'b0;
        ed = ev ? mq[0].last : 1'b0;
        er = (mq.size() <= 1);
        chk("msb_x",     x_m,   em);
        chk("msb_valid", xv_m,  ev);
        chk("msb_done",  dn_m,  ed);
        chk("msb_ready", rdy_m, er);
        chk("lsb_x",     x_l,   el);
        chk("lsb_valid", xv_l,  ev);
        chk("lsb_done",  dn_l,  ed);
        chk("lsb_ready", rdy_l, er);
    end

    // Stream capture for literal expectations.
    logic [31:0] cap_m, cap_l;
    int          ncap, ndone, nfall;
    logic        prev_xv;

    always @(negedge clk) begin
        if (xv_m) begin
            cap_m = {cap_m[30:0], x_m};
            cap_l = {cap_l[30:0], x_l};
            ncap++;
        end
        if (dn_m) ndone++;
        if (prev_xv && !xv_m) nfall++;
        prev_xv = xv_m;
    end

    task automatic clear_cap();
        cap_m = 32'd0;
        cap_l = 32'd0;
        ncap  = 0;
        ndone = 0;
        nfall = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Offer a word and return just after the edge that accepts it (bounded wait).
    task automatic send_word(input logic [W-1:0] w);
        logic r;
        bit   got;
        got     = 1'b0;
        data_i  = w;
        valid_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            r = rdy_m;
            @(posedge clk);
            #2;
            if (r) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL accept_timeout: word %0h not accepted within 20 cycles", w);
        end
    endtask

    task automatic check_stream(input string name, input int n, input logic [31:0] em,
                                input logic [31:0] el, input int nd);
        chk({name, "_len"},  ncap,  n);
        chk({name, "_msb"},  cap_m, em);
        chk({name, "_lsb"},  cap_l, el);
        chk({name, "_done"}, ndone, nd);
        chk({name, "_gaps"}, nfall, 1);
    endtask

    initial begin
        prev_xv = 1'b0;
        clear_cap();
        reset   = 1'b1;
        valid_i = 1'b1;
        data_i  = 4'b1011;

        // Reset held with valid_i high: nothing accepted.
        step(2);
        chk("rst_ready", rdy_m, 1);
        chk("rst_x",     x_m,   0);
        chk("rst_xvalid", xv_m, 0);
        chk("rst_done",  dn_m,  0);
        reset   = 1'b0;
        valid_i = 1'b0;
        step(1);
        chk("post_rst_xvalid", xv_m, 0);

        // Single frame 1011.
        clear_cap();
        send_word(4'b1011);
        valid_i = 1'b0;
        step(8);
`ifdef PISO_PARITY_EN
        check_stream("single", FL, 32'b10111, 32'b11011, 1);
`else
        check_stream("single", FL, 32'b1011, 32'b1101, 1);
`endif

        // Back-to-back 1010 then 0110, valid_i held high.
        clear_cap();
        send_word(4'b1010);
        send_word(4'b0110);
        valid_i = 1'b0;
        step(8);
`ifdef PISO_PARITY_EN
        check_stream("b2b", 2 * FL, 32'b1010001100, 32'b0101001100, 2);
`else
        check_stream("b2b", 2 * FL, 32'b10100110, 32'b01010110, 2);
`endif

        // Busy-time input ignored, then accepted at the final-bit edge.
        clear_cap();
        send_word(4'b1100);
        send_word(4'b0011);
        valid_i = 1'b0;
        step(8);
`ifdef PISO_PARITY_EN
        check_stream("busy", 2 * FL, 32'b1100000110, 32'b0011011000, 2);
`else
        check_stream("busy", 2 * FL, 32'b11000011, 32'b00111100, 2);
`endif

        // Asynchronous reset two bits into a frame.
        clear_cap();
        send_word(4'b1111);
        valid_i = 1'b0;
        step(1);
        #1 reset = 1'b1;
        #1;
        chk("abort_x",      x_m,   0);
        chk("abort_xvalid", xv_m,  0);
        chk("abort_done",   dn_m,  0);
        chk("abort_ready",  rdy_m, 1);
        step(2);
        chk("abort_no_done", ndone, 0);
        reset = 1'b0;
        step(1);
        clear_cap();
        send_word(4'b0101);
        valid_i = 1'b0;
        step(8);
`ifdef PISO_PARITY_EN
        check_stream("after_rst", FL, 32'b01010, 32'b10100, 1);
`else
        check_stream("after_rst", FL, 32'b0101, 32'b1010, 1);
`endif

`ifdef PISO_PARITY_EN
        // Parity zero case.
        clear_cap();
        send_word(4'b1001);
        valid_i = 1'b0;
        step(8);
        check_stream("parity0", FL, 32'b10010, 32'b10010, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
